// File: rtl/pe_rr_sched_if.sv
// Handshake bundle between the requesters, the round-robin scheduler and the shared PE controller.
// The scheduler takes the slave modport; the requester/PE side (or a bench) takes the master modport.
interface pe_rr_sched_if #(
   parameter int NUM_REQ     = 4,
   parameter int VECTOR_SIZE = 16,
   parameter int L_RAM_SIZE  = 4,
   parameter int ADDR_W      = 16
);
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*ADDR_W-1:0] req_base;
   logic [NUM_REQ-1:0]        gnt;
   logic [NUM_REQ-1:0]        resp_valid;
   logic                      resp_err;
   logic [VECTOR_SIZE-1:0]    resp_data;
   logic                      busy;
   logic                      pe_start;
   logic                      pe_done;
   logic                      pe_aresetn;
   logic [L_RAM_SIZE:0]       pe_rdaddr;
   logic [ADDR_W-1:0]         mem_addr;
   logic [VECTOR_SIZE-1:0]    pe_wrdata;

   modport slave (
      input  req, req_base, pe_done, pe_rdaddr, pe_wrdata,
      output gnt, resp_valid, resp_err, resp_data, busy,
             pe_start, pe_aresetn, mem_addr
   );

   modport master (
      output req, req_base, pe_done, pe_rdaddr, pe_wrdata,
      input  gnt, resp_valid, resp_err, resp_data, busy,
             pe_start, pe_aresetn, mem_addr
   );
endinterface

// File: rtl/pe_rr_sched.sv
// Round-robin scheduler sharing one start/done PE controller between NUM_REQ requesters,
// with base-address relocation of the PE read address and a watchdog that aborts a hung PE.
module pe_rr_sched #(
   parameter int NUM_REQ     = 4,
   parameter int VECTOR_SIZE = 16,
   parameter int L_RAM_SIZE  = 4,
   parameter int ADDR_W      = 16,
   parameter int TIMEOUT     = 1023
) (
   input  logic          aclk,
   input  logic          aresetn,
   pe_rr_sched_if.slave  bus
);
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int PW    = IDX_W + 1;
   localparam int WD_W  = $clog2(TIMEOUT + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_BUSY  = 3'd2;
   localparam logic [2:0] S_RESP  = 3'd3;
   localparam logic [2:0] S_ABORT = 3'd4;

   logic [2:0]             r_state;
   logic [IDX_W-1:0]       r_idx;
   logic [IDX_W-1:0]       r_ptr;
   logic [ADDR_W-1:0]      r_base;
   logic [WD_W-1:0]        r_wd;
   logic                   r_abort_cnt;
   logic                   r_resp_err;
   logic [VECTOR_SIZE-1:0] r_resp_data;

   logic                   w_found;
   logic [IDX_W-1:0]       w_sel;
   logic [ADDR_W-1:0]      w_sel_base;
   logic [NUM_REQ-1:0]     w_idx_oh;
   logic                   w_wd_exp;

   // Sum of two in-range indices folded back into 0..NUM_REQ-1.
   function automatic logic [IDX_W-1:0] wrap_idx(input logic [PW-1:0] v);
      if (v >= PW'(NUM_REQ))
         return IDX_W'(v - PW'(NUM_REQ));
      return IDX_W'(v);
   endfunction

   function automatic logic [ADDR_W-1:0] reloc_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [L_RAM_SIZE:0] offs);
      return base + ADDR_W'(offs);
   endfunction

   // First pending request at or after the round-robin pointer.
   always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!w_found && bus.req[wrap_idx({1'b0, r_ptr} + PW'(k))]) begin
            w_found = 1'b1;
            w_sel   = wrap_idx({1'b0, r_ptr} + PW'(k));
         end
      end
   end

   always_comb begin
      w_sel_base = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (w_sel == IDX_W'(i))
            w_sel_base = bus.req_base[i*ADDR_W +: ADDR_W];
   end

   always_comb begin
      w_idx_oh        = '0;
      w_idx_oh[r_idx] = 1'b1;
   end

   assign w_wd_exp = (r_wd == WD_W'(TIMEOUT - 1));

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_ptr       <= '0;
         r_wd        <= '0;
         r_abort_cnt <= 1'b0;
         r_resp_err  <= 1'b0;
         r_resp_data <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_idx   <= w_sel;
                  r_state <= S_START;
               end
            end
            S_START: begin
               r_wd    <= '0;
               r_state <= S_BUSY;
            end
            S_BUSY: begin
               r_wd <= r_wd + WD_W'(1);
               // A done arriving on the last watchdog cycle still counts as success.
               if (bus.pe_done) begin
                  r_resp_data <= bus.pe_wrdata;
                  r_resp_err  <= 1'b0;
                  r_state     <= S_RESP;
               end else if (w_wd_exp) begin
                  r_resp_data <= '0;
                  r_abort_cnt <= 1'b0;
                  r_state     <= S_ABORT;
               end
            end
            S_ABORT: begin
               r_abort_cnt <= 1'b1;
               if (r_abort_cnt) begin
                  r_resp_err <= 1'b1;
                  r_state    <= S_RESP;
               end
            end
            S_RESP: begin
               r_ptr   <= wrap_idx({1'b0, r_idx} + PW'(1));
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Base is only meaningful while a service is in flight, so it carries no reset.
   always_ff @(posedge aclk) begin
      if (r_state == S_IDLE && w_found)
         r_base <= w_sel_base;
   end

   assign bus.gnt        = (r_state != S_IDLE) ? w_idx_oh : '0;
   assign bus.resp_valid = (r_state == S_RESP) ? w_idx_oh : '0;
   assign bus.resp_err   = r_resp_err;
   assign bus.resp_data  = r_resp_data;
   assign bus.busy       = (r_state != S_IDLE);
   assign bus.pe_start   = (r_state == S_START);
   assign bus.pe_aresetn = aresetn & (r_state != S_ABORT);
   assign bus.mem_addr   = (r_state == S_START || r_state == S_BUSY)
                           ? reloc_addr(r_base, bus.pe_rdaddr) : '0;

endmodule

// File: tb/tb_pe_rr_sched.sv
// Scoreboard bench for pe_rr_sched: stimulus pushes expected responses, a monitor pops them on resp_valid.
module tb_pe_rr_sched;
   localparam int NUM_REQ     = 4;
   localparam int VECTOR_SIZE = 16;
   localparam int L_RAM_SIZE  = 4;
   localparam int ADDR_W      = 16;
   localparam int TIMEOUT     = 64;

   logic aclk    = 1'b0;
   logic aresetn = 1'b1;
   always #5 aclk = ~aclk;

   pe_rr_sched_if #(.NUM_REQ(NUM_REQ), .VECTOR_SIZE(VECTOR_SIZE),
                    .L_RAM_SIZE(L_RAM_SIZE), .ADDR_W(ADDR_W)) bus ();

   pe_rr_sched #(.NUM_REQ(NUM_REQ), .VECTOR_SIZE(VECTOR_SIZE), .L_RAM_SIZE(L_RAM_SIZE),
                 .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .aclk(aclk), .aresetn(aresetn), .bus(bus));

   typedef struct packed {
      logic [2:0]  idx;
      logic        err;
      logic [15:0] data;
   } exp_t;

   exp_t        exp_q[$];
   int          grant_log[$];
   int          checks    = 0;
   int          errors    = 0;
   int          start_cnt = 0;
   int          pe_delay  = -1;
   bit          multi_gnt = 1'b0;
   logic [15:0] data_tbl [NUM_REQ];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, want, $time);
      end
   endtask

   function automatic int oh2idx(input logic [NUM_REQ-1:0] oh);
      for (int i = 0; i < NUM_REQ; i++)
         if (oh[i]) return i;
      return -1;
   endfunction

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // Monitor / scoreboard
   initial begin
      logic [NUM_REQ-1:0] prev_gnt;
      exp_t e;
      prev_gnt = '0;
      forever begin
         @(negedge aclk);
         if ($countones(bus.gnt) > 1) multi_gnt = 1'b1;
         if (bus.gnt != '0 && prev_gnt == '0) grant_log.push_back(oh2idx(bus.gnt));
         prev_gnt = bus.gnt;
         if (bus.pe_start) start_cnt++;
         if (bus.resp_valid != '0) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL resp_unexpected actual=%b required=no response", bus.resp_valid);
            end else begin
               e = exp_q.pop_front();
               chk("resp_valid", 32'(bus.resp_valid), 32'(1) << e.idx);
               chk("resp_err", 32'(bus.resp_err), 32'(e.err));
               chk("resp_data", 32'(bus.resp_data), 32'(e.data));
            end
         end
      end
   end

   // PE model: sweeps rdaddr, raises pe_done pe_delay cycles after start (never if negative).
   initial begin
      int g;
      bus.pe_done   = 1'b0;
      bus.pe_rdaddr = '0;
      bus.pe_wrdata = '0;
      forever begin
         @(negedge aclk);
         if (bus.pe_start === 1'b1) begin
            g = oh2idx(bus.gnt);
            if (g >= 0) bus.pe_wrdata = data_tbl[g];
            for (int t = 1; t < 300; t++) begin
               tick();
               if (bus.gnt == '0) break;
               bus.pe_rdaddr = 5'(t);
               bus.pe_done   = (t == pe_delay);
            end
            bus.pe_done   = 1'b0;
            bus.pe_rdaddr = '0;
         end
      end
   end

   task automatic issue(input int idx, input logic [15:0] base, input logic err, input bit push);
      bus.req_base[idx*ADDR_W +: ADDR_W] = base;
      bus.req[idx] = 1'b1;
      if (push) exp_q.push_back({3'(idx), err, err ? 16'h0000 : data_tbl[idx]});
   endtask

   task automatic drop(input int idx);
      tick();
      bus.req[idx] = 1'b0;
   endtask

   task automatic wait_start(input logic [NUM_REQ-1:0] mask, output int n);
      n = 0;
      do begin
         @(negedge aclk);
         n++;
      end while (!bus.pe_start && n < 20);
      chk("start_seen", 32'(bus.pe_start), 32'd1);
      chk("gnt_at_start", 32'(bus.gnt), 32'(mask));
   endtask

   // Starts at the START-cycle negedge (t=0) and runs to the response pulse.
   task automatic measure(input bit chk_addr, input logic [15:0] base,
                          output int first_low, output int low_cnt, output int resp_t,
                          output logic [15:0] addr16);
      first_low = -1;
      low_cnt   = 0;
      resp_t    = -1;
      addr16    = '0;
      for (int t = 0; t < 200; t++) begin
         if (t > 0) @(negedge aclk);
         if (chk_addr && t < 32)
            chk("mem_addr", 32'(bus.mem_addr), 32'(16'(base + 16'(t))));
         if (t == 16) addr16 = bus.mem_addr;
         if (!bus.pe_aresetn) begin
            if (first_low < 0) first_low = t;
            low_cnt++;
         end
         if (bus.resp_valid != '0) begin
            resp_t = t;
            break;
         end
      end
      if (resp_t < 0) begin
         checks++;
         errors++;
         $display("FAIL resp_wait actual=no response required=response within 200 cycles");
      end
   endtask

   initial begin
      int n, fl, lc, rt;
      logic [15:0] a16;
      bus.req      = '0;
      bus.req_base = '0;
      data_tbl[0] = 16'hA000; data_tbl[1] = 16'hA111;
      data_tbl[2] = 16'h3C00; data_tbl[3] = 16'h5555;

      // Reset state
      #2 aresetn = 1'b0;
      #1;
      chk("rst_gnt", 32'(bus.gnt), 0);
      chk("rst_resp_valid", 32'(bus.resp_valid), 0);
      chk("rst_resp_err", 32'(bus.resp_err), 0);
      chk("rst_resp_data", 32'(bus.resp_data), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_pe_start", 32'(bus.pe_start), 0);
      chk("rst_pe_aresetn", 32'(bus.pe_aresetn), 0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 0);
      repeat (3) @(posedge aclk);
      @(negedge aclk) aresetn = 1'b1;
      #1 chk("pe_aresetn_released", 32'(bus.pe_aresetn), 1);

      // Single request, req[2], base 0x0100, done 40 cycles after start
      pe_delay = 40;
      tick();
      issue(2, 16'h0100, 1'b0, 1'b1);
      @(negedge aclk);
      chk("gnt_before_edge", 32'(bus.gnt), 0);
      wait_start(4'b0100, n);
      chk("gnt_latency", 32'(n), 1);
      measure(1'b1, 16'h0100, fl, lc, rt, a16);
      chk("single_resp_t", 32'(rt), 41);
      chk("single_no_abort", 32'(lc), 0);
      drop(2);
      chk("single_start_cnt", 32'(start_cnt), 1);
      chk("single_gnt_clear", 32'(bus.gnt), 0);

      // Timeout on req[3]: 64 BUSY cycles, 2-cycle PE reset, error response
      pe_delay = -1;
      issue(3, 16'h0040, 1'b1, 1'b1);
      wait_start(4'b1000, n);
      measure(1'b0, 16'h0040, fl, lc, rt, a16);
      chk("abort_first_low", 32'(fl), 65);
      chk("abort_low_cycles", 32'(lc), 2);
      chk("abort_resp_t", 32'(rt), 67);
      drop(3);

      // Fairness: all four, then req[0] again
      pe_delay = 5;
      grant_log.delete();
      for (int i = 0; i < NUM_REQ; i++) issue(i, 16'(16'h1000 * i), 1'b0, 1'b1);
      for (int k = 0; k < NUM_REQ; k++) begin
         wait_start(4'(1 << k), n);
         measure(1'b0, 16'h0000, fl, lc, rt, a16);
         chk("fair_resp_t", 32'(rt), 6);
         drop(k);
      end
      issue(0, 16'h2000, 1'b0, 1'b1);
      wait_start(4'b0001, n);
      measure(1'b0, 16'h0000, fl, lc, rt, a16);
      drop(0);
      chk("fair_log_size", 32'(grant_log.size()), 5);
      if (grant_log.size() == 5) begin
         chk("fair_g0", 32'(grant_log[0]), 0);
         chk("fair_g1", 32'(grant_log[1]), 1);
         chk("fair_g2", 32'(grant_log[2]), 2);
         chk("fair_g3", 32'(grant_log[3]), 3);
         chk("fair_g4", 32'(grant_log[4]), 0);
      end
      chk("one_hot_gnt", 32'(multi_gnt), 0);

      // Collision: done on BUSY cycle 64 wins over the watchdog
      pe_delay = 64;
      issue(1, 16'h0300, 1'b0, 1'b1);
      wait_start(4'b0010, n);
      measure(1'b0, 16'h0000, fl, lc, rt, a16);
      chk("coll_no_abort", 32'(lc), 0);
      chk("coll_resp_t", 32'(rt), 65);
      drop(1);

      // Address wrap: base 0xFFF8 + rdaddr 16 = 0x0008
      pe_delay = 40;
      issue(2, 16'hFFF8, 1'b0, 1'b1);
      wait_start(4'b0100, n);
      measure(1'b1, 16'hFFF8, fl, lc, rt, a16);
      chk("wrap_addr16", 32'(a16), 32'h0008);
      drop(2);

      // Reset mid-BUSY on req[3], then req[1]|req[3] from a restarted pointer
      pe_delay = -1;
      issue(3, 16'h0500, 1'b0, 1'b0);
      wait_start(4'b1000, n);
      repeat (10) @(negedge aclk);
      #2 aresetn = 1'b0;
      #1;
      chk("mid_rst_gnt", 32'(bus.gnt), 0);
      chk("mid_rst_resp_valid", 32'(bus.resp_valid), 0);
      chk("mid_rst_pe_start", 32'(bus.pe_start), 0);
      chk("mid_rst_busy", 32'(bus.busy), 0);
      chk("mid_rst_pe_aresetn", 32'(bus.pe_aresetn), 0);
      bus.req = '0;
      repeat (3) @(posedge aclk);
      #1 chk("mid_rst_pe_aresetn_held", 32'(bus.pe_aresetn), 0);
      @(negedge aclk) aresetn = 1'b1;
      pe_delay = 3;
      tick();
      issue(1, 16'h0600, 1'b0, 1'b1);
      issue(3, 16'h0700, 1'b0, 1'b1);
      wait_start(4'b0010, n);
      measure(1'b0, 16'h0000, fl, lc, rt, a16);
      drop(1);
      wait_start(4'b1000, n);
      measure(1'b0, 16'h0000, fl, lc, rt, a16);
      drop(3);

      repeat (3) @(negedge aclk);
      chk("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=still running required=finished");
      $fatal(1, "simulation time limit");
   end

endmodule
